// File: rtl/output_stream_tx.sv
// output_stream_tx: AXI-Stream transmitter for convolution results.
// Buffers result words in a FIFO and frames each output matrix with TLAST.
module output_stream_tx #(
  parameter int OUTW  = 32,
  parameter int DEPTH = 8,
  parameter int R     = 9,
  parameter int C     = 8,
  parameter int MAXK  = 4,
  localparam int K_BITS   = $clog2(MAXK + 1),
  localparam int N_BITS   = $clog2(R * C + 1),
  localparam int CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [K_BITS-1:0]   K,
  input  logic [OUTW-1:0]     in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUTW-1:0]     AXIS_TDATA,
  output logic                AXIS_TVALID,
  input  logic                AXIS_TREADY,
  output logic                AXIS_TLAST,
  output logic                matrix_sent,
  output logic [CNT_BITS-1:0] fifo_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(DEPTH);

  logic [OUTW-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_BITS-1:0] count_q, count_d;
  logic [N_BITS-1:0]   sent_cnt_q, sent_cnt_d;
  logic                sent_q, sent_d;

  logic              push;
  logic              pop;
  logic              last;
  logic [N_BITS-1:0] k_n;
  logic [N_BITS-1:0] rows;
  logic [N_BITS-1:0] cols;
  logic [N_BITS-1:0] n_words;
  logic [N_BITS-1:0] last_idx;

  // Output matrix size for the current kernel: (R-K+1)*(C-K+1).
  always_comb begin
    k_n      = N_BITS'(K);
    rows     = N_BITS'(R) - k_n + N_BITS'(1);
    cols     = N_BITS'(C) - k_n + N_BITS'(1);
    n_words  = rows * cols;
    last_idx = n_words - N_BITS'(1);
  end

  assign in_ready    = (count_q < CNT_FULL);
  assign AXIS_TVALID = (count_q != '0);
  assign AXIS_TDATA  = mem_q[rd_ptr_q];
  assign last        = (sent_cnt_q == last_idx);
  assign AXIS_TLAST  = AXIS_TVALID && last;
  assign matrix_sent = sent_q;
  assign fifo_count  = count_q;

  assign push = in_valid && in_ready;
  assign pop  = AXIS_TVALID && AXIS_TREADY;

  // Next-state for pointers, occupancy and matrix framing.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    sent_cnt_d = sent_cnt_q;
    sent_d     = 1'b0;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_BITS'(1);
      2'b01:   count_d = count_q - CNT_BITS'(1);
      default: count_d = count_q;
    endcase
    if (pop) begin
      if (last) begin
        sent_cnt_d = '0;
        sent_d     = 1'b1;
      end else begin
        sent_cnt_d = sent_cnt_q + N_BITS'(1);
      end
    end
  end

  // Control state; reset drops buffered words and the partial matrix.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sent_cnt_q <= '0;
      sent_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sent_cnt_q <= sent_cnt_d;
      sent_q     <= sent_d;
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: doc/output_stream_tx.md
Name: output_stream_tx

Overview:
- AXI-Stream transmitter at the back end of the 2D convolution accelerator; mirror of the input-memory receiver.
- Accepts convolution results from the MAC/compute datapath over a valid/ready push interface and buffers them in a FIFO.
- Streams results out as an AXIS master, asserts TLAST on the final element of each output matrix, and pulses matrix_sent when that element is accepted.

Parameters:
- OUTW, 32, width of one output word (result of INW x INW MAC plus accumulation growth)
- DEPTH, 8, FIFO capacity in words; DEPTH >= 2; need not be a power of two
- R, 9, input matrix rows
- C, 8, input matrix columns
- MAXK, 4, maximum kernel size; K_BITS = $clog2(MAXK+1); N_BITS = $clog2(R*C+1); CNT_BITS = $clog2(DEPTH+1)

Ports:
- clk  in  1  clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- K  in  K_BITS  kernel size of the matrix in flight; valid range 1..MAXK, K <= R, K <= C
- in_data  in  OUTW  result word from the compute datapath (signed, passed through unmodified)
- in_valid  in  1  in_data is valid
- in_ready  out  1  FIFO can accept a word
- AXIS_TDATA  out  OUTW  head-of-FIFO word
- AXIS_TVALID  out  1  FIFO non-empty
- AXIS_TREADY  in  1  downstream accepts
- AXIS_TLAST  out  1  current TDATA is the last element of the output matrix
- matrix_sent  out  1  one-cycle pulse after the last element of a matrix is accepted
- fifo_count  out  CNT_BITS  current occupancy (debug/status)

Behaviour:
- Reset (reset_n=0, asynchronous): wr_ptr=rd_ptr=0, count=0, sent_cnt=0, matrix_sent=0.
- Reset outputs: in_ready=1, AXIS_TVALID=0, AXIS_TLAST=0, fifo_count=0. FIFO storage is not reset.
- Reset mid-stream discards all buffered words and the partial matrix count. The first push after release starts a new matrix.
- Push: push = in_valid && in_ready. Write mem[wr_ptr] <= in_data. wr_ptr wraps from DEPTH-1 to 0.
- Pop: pop = AXIS_TVALID && AXIS_TREADY. rd_ptr wraps from DEPTH-1 to 0.
- in_ready = (count < DEPTH); combinational from registered count only, with no dependence on AXIS_TREADY.
- When full, in_ready=0 even if a pop occurs that cycle.
- Simultaneous push and pop when 0 < count < DEPTH: count is unchanged and both pointers advance.
- Push into an empty FIFO: word appears on AXIS_TDATA with AXIS_TVALID=1 the next cycle (latency 1). There is no combinational in-to-out bypass.
- AXIS_TVALID = (count != 0).
- AXIS_TDATA = mem[rd_ptr], read combinationally from the register array.
- While TVALID=1 and TREADY=0, TDATA and TLAST hold stable.
- TVALID never deasserts without a pop.
- Matrix tracking: N = (R-K+1)*(C-K+1), computed at N_BITS width.
- sent_cnt increments on each pop.
- AXIS_TLAST = AXIS_TVALID && (sent_cnt == N-1).
- Pop with TLAST=1: sent_cnt <= 0, and matrix_sent <= 1 for exactly one cycle. matrix_sent is registered, so it is high the cycle after the handshake.
- K must be held constant from the first push of a matrix until its TLAST handshake. Behaviour under K change mid-matrix is undefined.
- Back-to-back matrices: words of matrix n+1 may already be buffered behind matrix n. Counting restarts cleanly at the TLAST pop with no bubble required.
- K=1 gives N=R*C (72 at defaults). K=MAXK=4 gives N=30 at defaults.
- No data is dropped or duplicated; every pushed word is emitted exactly once, in order.

Test Plan:
- Reset then idle: hold reset_n=0 mid-cycle -> outputs clear immediately (async). After release: in_ready=1, TVALID=0, fifo_count=0.
- Full streaming, TREADY=1 constant, K=4, push 30 words 1..30 on consecutive cycles -> TDATA 1..30 each one cycle after push. TLAST=1 only with 30. matrix_sent high the cycle after the 30th pop. fifo_count never exceeds 1.
- Backpressure, TREADY=0, DEPTH=8, push 10 words -> in_ready drops after 8 accepted, fifo_count=8. TDATA holds word 1 stable. Raise TREADY: words 1..10 emerge in order with no loss.
- Wrap and simultaneous events, K=1 (N=72), random in_valid/TREADY, 3 matrices -> output equals input order. TLAST exactly on each 72nd pop. Pointers wrap past DEPTH-1. Push+pop at count=DEPTH-1 keeps count constant.
- Back-to-back matrices, K=4, push 60 words continuously with TREADY toggling 50% -> TLAST on words 30 and 60. Two matrix_sent pulses. sent_cnt restarts at 0 for word 31.
- Reset mid-matrix after 12 pops with 5 words buffered -> TVALID=0 and count cleared. A new 30-word matrix then produces TLAST on its 30th word, not its 18th.
